picmicro_timer0: RTL and testbench
==================================

// Module: picmicro_timer0
// PURPOSE
//  Timer0 peripheral on the core's external-peripheral bus. It provides TMR0 (0x001/0x101) and OPTION_REG (0x081/0x181).
//  The core drives addr/data_in/wr_en and muxes data_out into register-file reads.
//  8-bit counter clocked by instruction cycles or external T0CKI, with a shared 8-bit prescaler.
//  Raises a one-clk overflow pulse that the core ORs into INTCON.T0IF.
// PARAMETERS
//  TMR0_RESET    8'h00  TMR0 value after reset
//  OPTION_RESET  8'hFF  OPTION_REG value after reset (PSA=1, T0CS=1)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous active-high reset
//  addr        in   9  register-file address from core (extern_peripherals_addr)
//  data_in     in   8  write data from core ALU (extern_peripherals_data_in)
//  wr_en       in   1  one-clk write strobe, qualified by addr
//  instr_tick  in   1  one-clk pulse per instruction cycle (every 4th clk, from decoder)
//  t0cki       in   1  asynchronous external clock pin
//  data_out    out  8  read data (extern_peripherals_data_out); 0x00 when addr unmatched
//  t0if_set    out  1  one-clk pulse on TMR0 overflow 0xFF->0x00
//  option_out  out  8  current OPTION_REG, for other peripherals
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Decode: TMR0 hit = addr[7:0]==8'h01; OPTION hit = addr[7:0]==8'h81; addr[8] ignored.
//  Reads: data_out combinational: TMR0 hit -> tmr0; OPTION hit -> option; else 8'h00.
//  Reset: tmr0=TMR0_RESET, option=OPTION_RESET, prescaler=0, inhibit=0, sync flops=0, t0if_set=0.
//  OPTION fields: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS. Bits [7:6] are stored and read back but unused here.
//  Source event (tick_evt):
//   T0CS=0 -> tick_evt = instr_tick.
//   T0CS=1 -> t0cki passes through 2 sync flops plus 1 edge flop.
//    T0SE=0 counts rising edges; T0SE=1 counts falling edges.
//    tick_evt is a one-clk pulse, 3 clk after the pin edge.
//  Prescaler (PSA=0): 8-bit counter increments on each tick_evt.
//   TMR0 increments when the incremented prescaler's low PS+1 bits are all zero.
//   Ratio is 1:2^(PS+1) (PS=0 -> 1:2 ... PS=7 -> 1:256); prescaler wraps 0xFF->0x00.
//  PSA=1: prescaler bypassed and held at 0; every tick_evt increments TMR0.
//  Increment: tmr0 <= tmr0+1 mod 256, registered.
//   On 0xFF->0x00, t0if_set=1 for exactly that clk (registered, same edge tmr0 becomes 0x00).
//  TMR0 write (wr_en & TMR0 hit): tmr0 <= data_in; prescaler <= 0; inhibit <= 2.
//   While inhibit!=0, TMR0 increments are suppressed.
//   Each instr_tick decrements inhibit, whether or not a tick_evt occurs.
//   The prescaler keeps counting while inhibited.
//  OPTION write: option <= data_in next clk; prescaler <= 0 iff PSA or PS changes.
//   New settings apply from the following clk.
//  Simultaneous write and increment on the same clk: the write wins, the increment is lost, and no t0if_set is issued.
//  Simultaneous rst and anything: reset wins.
//   rst mid-prescale clears all state; an in-flight synchronized edge is discarded.
//  wr_en with no hit: no state change.
// CONFIGURATION
//  TIMER0_EXT_CLK_EN defined:
//   t0cki synchronizer and edge logic are present; T0CS/T0SE act as above.
//  TIMER0_EXT_CLK_EN undefined:
//   Synchronizer is not built and t0cki is ignored.
//   tick_evt = instr_tick regardless of T0CS; T0CS/T0SE are still stored and read back.
// TESTING
//  T1 reset, PSA=1 via OPTION write 8'hC8 (T0CS=0), 5 instr_ticks -> TMR0 reads 0x05; t0if_set never high.
//  T2 write TMR0=0xFE, then 4 ticks -> inhibited 2 ticks, reads 0xFF then 0x00.
//   t0if_set is high for exactly 1 clk, on the 0x00 edge.
//  T3 OPTION=8'hC1 (PSA=0, PS=1, 1:4), TMR0=0 after inhibit, 16 ticks -> TMR0=0x04; OPTION readback 0xC1.
//  T4 TIMER0_EXT_CLK_EN, OPTION=8'hE8 (T0CS=1, rising, PSA=1), 3 t0cki pulses.
//   -> TMR0=0x03; each increment is 3 clk after the rising edge; instr_tick has no effect.
//  T5 TMR0 write coinciding with an overflow increment (tmr0=0xFF) -> TMR0=written value, t0if_set stays 0.
//  T6 reads at addr 0x101/0x181 mirror 0x001/0x081; addr 0x005 -> data_out=0x00; rst mid-count -> TMR0=0x00, OPTION=0xFF.

Source files
------------

// File: rtl/picmicro_timer0.sv
`default_nettype none
// ============================================================================
// Module   : picmicro_timer0
// Purpose  : PIC-style Timer0 (TMR0 + OPTION_REG) with shared 8-bit prescaler.
//            Optional T0CKI synchroniser when TIMER0_EXT_CLK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module picmicro_timer0 #(
  parameter logic [7:0] TMR0_RESET   = 8'h00,
  parameter logic [7:0] OPTION_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  input  logic       instr_tick,
  input  logic       t0cki,
  output logic [7:0] data_out,
  output logic       t0if_set,
  output logic [7:0] option_out
);

  localparam logic [7:0] c_TMR0_ADDR   = 8'h01;
  localparam logic [7:0] c_OPTION_ADDR = 8'h81;

  logic [7:0] r_tmr0;
  logic [7:0] r_option;
  logic [7:0] r_psc;
  logic [1:0] r_inhibit;
  logic       r_t0if;

  logic       w_tmr0_hit;
  logic       w_opt_hit;
  logic       w_tmr0_wr;
  logic       w_opt_wr;
  logic       w_psa;
  logic [2:0] w_ps;
  logic       w_tick_evt;
  logic [7:0] w_psc_inc;
  logic [7:0] w_psc_mask;
  logic       w_psc_match;
  logic       w_inc;
  logic       w_psc_cfg_chg;

  assign w_tmr0_hit = (addr[7:0] == c_TMR0_ADDR);
  assign w_opt_hit  = (addr[7:0] == c_OPTION_ADDR);
  assign w_tmr0_wr  = wr_en & w_tmr0_hit;
  assign w_opt_wr   = wr_en & w_opt_hit;

  assign w_psa = r_option[3];
  assign w_ps  = r_option[2:0];

`ifdef TIMER0_EXT_CLK_EN
  logic w_t0cs;
  logic w_t0se;
  logic r_sync1;
  logic r_sync2;
  logic r_edge;
  logic w_ext_evt;

  assign w_t0cs = r_option[5];
  assign w_t0se = r_option[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= t0cki;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  // Pulse lands in the third clk after the pin edge, so TMR0 moves on that edge.
  assign w_ext_evt  = w_t0se ? (r_edge & ~r_sync2) : (r_sync2 & ~r_edge);
  assign w_tick_evt = w_t0cs ? w_ext_evt : instr_tick;
`else
  logic w_unused_t0cki;
  assign w_unused_t0cki = t0cki;
  assign w_tick_evt     = instr_tick;
`endif

  // Ratio 1:2^(PS+1): TMR0 steps when the low PS+1 bits of the next count are zero.
  assign w_psc_inc     = r_psc + 8'd1;
  assign w_psc_mask    = 8'hFF >> (3'd7 - w_ps);
  assign w_psc_match   = ((w_psc_inc & w_psc_mask) == 8'h00);
  assign w_psc_cfg_chg = (data_in[3] != w_psa) || (data_in[2:0] != w_ps);

  assign w_inc = w_tick_evt & (w_psa | w_psc_match) & (r_inhibit == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc <= 8'h00;
    end else if (w_tmr0_wr) begin
      r_psc <= 8'h00;
    end else if (w_opt_wr && w_psc_cfg_chg) begin
      r_psc <= 8'h00;
    end else if (w_psa) begin
      r_psc <= 8'h00;
    end else if (w_tick_evt) begin
      r_psc <= w_psc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inhibit <= 2'd0;
    end else if (w_tmr0_wr) begin
      r_inhibit <= 2'd2;
    end else if (instr_tick && (r_inhibit != 2'd0)) begin
      r_inhibit <= r_inhibit - 2'd1;
    end
  end

  // A write on the same clk as an increment swallows the increment and its flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr0 <= TMR0_RESET;
      r_t0if <= 1'b0;
    end else begin
      r_t0if <= 1'b0;
      if (w_tmr0_wr) begin
        r_tmr0 <= data_in;
      end else if (w_inc) begin
        r_tmr0 <= r_tmr0 + 8'd1;
        r_t0if <= (r_tmr0 == 8'hFF);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_option <= OPTION_RESET;
    end else if (w_opt_wr) begin
      r_option <= data_in;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (w_tmr0_hit) begin
      data_out = r_tmr0;
    end else if (w_opt_hit) begin
      data_out = r_option;
    end
  end

  assign t0if_set   = r_t0if;
  assign option_out = r_option;

endmodule
`default_nettype wire

// File: tb/tb_picmicro_timer0.sv
`default_nettype none
// ============================================================================
// Module   : tb_picmicro_timer0
// Purpose  : Directed + random checks of picmicro_timer0 against a cycle model.
// Revision : 1.0  initial release
// ============================================================================
module tb_picmicro_timer0;

`ifdef TIMER0_EXT_CLK_EN
  localparam bit EXT_BUILD = 1'b1;
`else
  localparam bit EXT_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] addr = 9'h000;
  logic [7:0] data_in = 8'h00;
  logic       wr_en = 1'b0;
  logic       instr_tick = 1'b0;
  logic       t0cki = 1'b0;
  logic [7:0] data_out;
  logic       t0if_set;
  logic [7:0] option_out;

  int total = 0;
  int bad   = 0;

  // Reference state: plain integers, prescaler judged by modulo of the ratio.
  int         m_tmr  = 0;
  int         m_psc  = 0;
  int         m_inh  = 0;
  logic [7:0] m_opt  = 8'hFF;
  logic       m_t0if = 1'b0;

  picmicro_timer0 dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .instr_tick (instr_tick),
    .t0cki      (t0cki),
    .data_out   (data_out),
    .t0if_set   (t0if_set),
    .option_out (option_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [8:0] a);
    if (a[7:0] == 8'h01) return 8'(m_tmr);
    if (a[7:0] == 8'h81) return m_opt;
    return 8'h00;
  endfunction

  task automatic m_update(input bit ext);
    bit evt, inc, hit_t, hit_o;
    int ratio;
    if (rst) begin
      m_tmr = 0; m_psc = 0; m_inh = 0; m_opt = 8'hFF; m_t0if = 1'b0;
      return;
    end
    hit_t = wr_en && (addr[7:0] == 8'h01);
    hit_o = wr_en && (addr[7:0] == 8'h81);
    evt   = (EXT_BUILD && m_opt[5]) ? ext : instr_tick;
    ratio = 1 << (int'(m_opt[2:0]) + 1);
    inc   = evt && (m_opt[3] || (((m_psc + 1) % ratio) == 0)) && (m_inh == 0);
    m_t0if = 1'b0;
    if (hit_t) m_tmr = int'(data_in);
    else if (inc) begin
      m_t0if = (m_tmr == 255);
      m_tmr  = (m_tmr + 1) % 256;
    end
    if (hit_t || (hit_o && ((data_in[3] != m_opt[3]) || (data_in[2:0] != m_opt[2:0]))) || m_opt[3])
      m_psc = 0;
    else if (evt) m_psc = (m_psc + 1) % 256;
    if (hit_t) m_inh = 2;
    else if (instr_tick && m_inh > 0) m_inh--;
    if (hit_o) m_opt = data_in;
  endtask

  task automatic cyc(input bit ext);
    @(posedge clk);
    m_update(ext);
    #1;
    chk("t0if_set", {7'd0, t0if_set}, {7'd0, m_t0if});
    chk("option_out", option_out, m_opt);
    chk("data_out", data_out, m_read(addr));
    wr_en = 1'b0;
    instr_tick = 1'b0;
    rst = 1'b0;
  endtask

  task automatic tick();
    repeat (3) cyc(1'b0);
    instr_tick = 1'b1;
    cyc(1'b0);
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1;
    cyc(1'b0);
  endtask

  task automatic rd(input string tag, input logic [8:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    // T1: reset state, then PSA=1 with instruction-cycle source.
    rst = 1'b1;
    cyc(1'b0);
    rd("rst_tmr0", 9'h001, 8'h00);
    rd("rst_option", 9'h081, 8'hFF);
    wr(9'h081, 8'hC8);
    repeat (5) tick();
    rd("T1_tmr0", 9'h001, 8'h05);

    // T2: write near overflow, two ticks swallowed, then wrap with a one-clk flag.
    wr(9'h001, 8'hFE);
    repeat (2) tick();
    rd("T2_inhibit", 9'h001, 8'hFE);
    tick();
    rd("T2_ff", 9'h001, 8'hFF);
    tick();
    chk("T2_t0if_hi", {7'd0, t0if_set}, 8'h01);
    rd("T2_wrap", 9'h001, 8'h00);
    cyc(1'b0);
    chk("T2_t0if_lo", {7'd0, t0if_set}, 8'h00);

    // T3: 1:4 prescale, prescaler runs through the inhibit window.
    wr(9'h081, 8'hC1);
    wr(9'h001, 8'h00);
    repeat (2) tick();
    repeat (16) tick();
    rd("T3_tmr0", 9'h001, 8'h04);
    rd("T3_option", 9'h081, 8'hC1);

`ifdef TIMER0_EXT_CLK_EN
    // T4: external rising edges, instr_tick ignored.
    wr(9'h081, 8'hE8);
    wr(9'h001, 8'h00);
    repeat (2) tick();
    addr = 9'h001;
    for (int n = 1; n <= 3; n++) begin
      t0cki = 1'b1;
      instr_tick = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      chk("T4_before", data_out, 8'(n - 1));
      cyc(1'b1);
      chk("T4_after", data_out, 8'(n));
      t0cki = 1'b0;
      repeat (3) cyc(1'b0);
    end
    rd("T4_tmr0", 9'h001, 8'h03);
`endif

    // T5: write lands on the same clk as the overflow increment.
    wr(9'h081, 8'hC8);
    wr(9'h001, 8'hFF);
    repeat (2) tick();
    repeat (3) cyc(1'b0);
    addr = 9'h001; data_in = 8'h5A; wr_en = 1'b1; instr_tick = 1'b1;
    cyc(1'b0);
    chk("T5_t0if", {7'd0, t0if_set}, 8'h00);
    rd("T5_tmr0", 9'h001, 8'h5A);

    // T6: mirrors, unmatched address, stray write, reset mid-count.
    rd("T6_mirror_tmr0", 9'h101, 8'h5A);
    rd("T6_mirror_opt", 9'h181, 8'hC8);
    rd("T6_unmatched", 9'h005, 8'h00);
    wr(9'h005, 8'h33);
    rd("T6_nohit_tmr0", 9'h001, 8'h5A);
    rd("T6_nohit_opt", 9'h081, 8'hC8);
    wr(9'h081, 8'hC1);
    repeat (7) tick();
    rst = 1'b1;
    cyc(1'b0);
    rd("T6_rst_tmr0", 9'h001, 8'h00);
    rd("T6_rst_opt", 9'h081, 8'hFF);

    // Random phase: mixed writes, reads, ticks and occasional reset.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(5, 0))
        0: addr = 9'h001;
        1: addr = 9'h101;
        2: addr = 9'h081;
        3: addr = 9'h181;
        default: addr = 9'($urandom);
      endcase
      instr_tick = ($urandom_range(3, 0) == 0);
      if ($urandom_range(11, 0) == 0) begin
        wr_en = 1'b1;
        data_in = 8'($urandom);
        if (EXT_BUILD) data_in[5] = 1'b0;
      end
      rst = ($urandom_range(149, 0) == 0);
      cyc(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
